// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer and the operand mux it feeds.
package operand_sequencer_pkg;

    localparam int OPERAND_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        DISPLAY = 2'b10
    } state_t;

    // Counter width for a modulo-n count; a single bit is the floor.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_sequencer_dwell_counter.sv
// Modulo-DWELL counter with enable and sync clear; o_wrap is high during the
// last count of each period, so the owner sees exactly one pulse per period.
module operand_sequencer_dwell_counter
    import operand_sequencer_pkg::*;
#(
    parameter int DWELL = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_wrap    = i_en && w_at_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Captures operands A and B from a shared bus on successive load strobes, then
// alternates the downstream mux select every DWELL cycles; all outputs registered.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int DWELL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic             mux_select,
    output logic             valid,
    output logic [1:0]       state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_sel;
    logic             r_valid;
    logic [WIDTH-1:0] w_opa_nxt;
    logic [WIDTH-1:0] w_opb_nxt;
    logic             w_sel_nxt;
    logic             w_valid_nxt;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    logic             w_wrap;

    // Counter only runs while displaying; any load restarts the dwell period.
    assign w_cnt_en  = (r_state == DISPLAY);
    assign w_cnt_clr = clear || load || (r_state != DISPLAY);

    operand_sequencer_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (w_cnt_en),
        .i_clr  (w_cnt_clr),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = LOAD_A;
        end else begin
            case (r_state)
                LOAD_A:  if (load) w_state_nxt = LOAD_B;
                LOAD_B:  if (load) w_state_nxt = DISPLAY;
                DISPLAY: if (load) w_state_nxt = LOAD_B;
                default: w_state_nxt = LOAD_A;
            endcase
        end
    end

    always_comb begin
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_sel_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        if (clear) begin
            w_opa_nxt = '0;
            w_opb_nxt = '0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (load) w_opa_nxt = data_in;
                end
                LOAD_B: begin
                    if (load) begin
                        w_opb_nxt   = data_in;
                        w_valid_nxt = 1'b1;
                    end
                end
                DISPLAY: begin
                    // A load re-enters at LOAD_B and wins over a dwell wrap.
                    if (load) begin
                        w_opa_nxt = data_in;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_sel_nxt   = r_sel ^ w_wrap;
                    end
                end
                default: begin
                    w_opa_nxt = '0;
                    w_opb_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sel   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_opa   <= w_opa_nxt;
            r_opb   <= w_opb_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign opA        = r_opa;
    assign opB        = r_opb;
    assign mux_select = r_sel;
    assign valid      = r_valid;
    assign state      = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with DWELL=8 and DWELL=1 instances.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear8 = 1'b0, load8 = 1'b0;
    logic [3:0] data8 = 4'h0;
    logic [3:0] opa8, opb8;
    logic       sel8, valid8;
    logic [1:0] state8;
    logic       clear1 = 1'b0, load1 = 1'b0;
    logic [3:0] data1 = 4'h0;
    logic [3:0] opa1, opb1;
    logic       sel1, valid1;
    logic [1:0] state1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(4), .DWELL(8)) u_dut8 (
        .clk(clk), .rst(rst), .clear(clear8), .load(load8), .data_in(data8),
        .opA(opa8), .opB(opb8), .mux_select(sel8), .valid(valid8), .state(state8)
    );

    operand_sequencer #(.WIDTH(4), .DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear1), .load(load1), .data_in(data1),
        .opA(opa1), .opB(opb1), .mux_select(sel1), .valid(valid1), .state(state1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all8(input string tag, input logic [3:0] a, input logic [3:0] b,
                              input logic s, input logic v, input logic [1:0] st);
        check({tag, ".opA"},   32'(opa8),   32'(a));
        check({tag, ".opB"},   32'(opb8),   32'(b));
        check({tag, ".sel"},   32'(sel8),   32'(s));
        check({tag, ".valid"}, 32'(valid8), 32'(v));
        check({tag, ".state"}, 32'(state8), 32'(st));
    endtask

    initial begin
        #2;
        check_all8("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        step();
        rst = 1'b0;
        step();

        // Two separate load pulses: A=3, B=C.
        data8 = 4'h3; load8 = 1'b1;
        step();
        check_all8("loadA", 4'h3, 4'h0, 1'b0, 1'b0, 2'b01);
        data8 = 4'hC;
        step();
        load8 = 1'b0;
        check_all8("loadB", 4'h3, 4'hC, 1'b0, 1'b1, 2'b10);

        // Select stays 0 for 8 cycles, 1 for 8, and so on; reload on a wrap
        // cycle where an unblocked toggle would have raised select.
        for (int i = 0; i < 40; i++) begin
            check($sformatf("dwell8.sel[%0d]", i), 32'(sel8), 32'((i / 8) % 2));
            if (i == 39) begin
                data8 = 4'h9; load8 = 1'b1;
            end
            step();
        end
        load8 = 1'b0;
        check_all8("reload_on_wrap", 4'h9, 4'hC, 1'b0, 1'b0, 2'b01);

        // Clear beats load in LOAD_B.
        clear8 = 1'b1; load8 = 1'b1; data8 = 4'hF;
        step();
        clear8 = 1'b0; load8 = 1'b0;
        check_all8("clear_vs_load", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);

        // Held load captures both operands on consecutive edges.
        load8 = 1'b1; data8 = 4'h5;
        step();
        data8 = 4'h6;
        step();
        load8 = 1'b0;
        check_all8("held_load", 4'h5, 4'h6, 1'b0, 1'b1, 2'b10);

        // Async reset mid-DISPLAY with select high, observed before the next edge.
        repeat (8) step();
        check("pre_rst.sel", 32'(sel8), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all8("async_rst", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        step();
        rst = 1'b0;
        step();

        // DWELL=1: select toggles each cycle, mux output alternates 1,2,...
        load1 = 1'b1; data1 = 4'h1;
        step();
        data1 = 4'h2;
        step();
        load1 = 1'b0;
        check("d1.state", 32'(state1), 32'd2);
        check("d1.valid", 32'(valid1), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("d1.sel[%0d]", i), 32'(sel1), 32'(i % 2));
            check($sformatf("d1.mux[%0d]", i), 32'(sel1 ? opb1 : opa1), (i % 2) ? 32'd2 : 32'd1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
